// File: rtl/n8_sm_to_c2_serial.sv
// Serial sign-magnitude to two's complement converter, 8 bits, one bit per cycle LSB first.
// Optional negative-zero flag port nz is built when N8_SM2C2_NEGZERO_FLAG_EN is defined.
module n8_sm_to_c2_serial (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x7_x0,
  input  logic       x_valid,
  output logic       x_ready,
  output logic [7:0] z7_z0,
  output logic       z_valid,
  input  logic       z_ready
`ifdef N8_SM2C2_NEGZERO_FLAG_EN
  ,
  output logic       nz
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  work_q, work_d;
  logic [6:0]  res_q, res_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        seen_q, seen_d;
  logic [7:0]  z_q, z_d;
  logic        nz_q, nz_d;
  logic        bit_b, rbit;

  assign bit_b = work_q[0];
  assign rbit  = bit_b ^ seen_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    z_d     = z_q;
    nz_d    = nz_q;
    x_ready = (state_q == IDLE);
    z_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (x_valid) begin
          work_d = {1'b0, x7_x0[6:0]};
          cnt_d  = 3'd0;
          seen_d = 1'b0;
          // The sign is consumed right here: it only selects the path.
          if (x7_x0[7]) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            z_d     = {1'b0, x7_x0[6:0]};
            nz_d    = 1'b0;
          end
        end
      end
      SHIFT: begin
        work_d = {1'b0, work_q[7:1]};
        res_d  = {rbit, res_q[6:1]};
        seen_d = seen_q | bit_b;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          z_d     = {rbit, res_q};
          // No one bit ever seen means the magnitude was zero.
          nz_d    = ~(seen_q | bit_b);
        end
      end
      DONE: begin
        if (z_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= 8'h00;
      res_q   <= 7'h00;
      cnt_q   <= 3'd0;
      seen_q  <= 1'b0;
      z_q     <= 8'h00;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      z_q     <= z_d;
      nz_q    <= nz_d;
    end
  end

  assign z7_z0 = z_q;

`ifdef N8_SM2C2_NEGZERO_FLAG_EN
  assign nz = nz_q;
`else
  logic nz_unused;
  assign nz_unused = nz_q;
`endif

endmodule

// File: tb/tb_n8_sm_to_c2_serial.sv
// Directed bench for n8_sm_to_c2_serial: abstract cycle model + per-cycle compare + literal checks.
module tb_n8_sm_to_c2_serial;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x7_x0 = 8'h00;
  logic       x_valid = 1'b0;
  logic       x_ready;
  logic [7:0] z7_z0;
  logic       z_valid;
  logic       z_ready = 1'b0;
  logic       nz;

  int checks = 0;
  int failures = 0;

  n8_sm_to_c2_serial dut (
    .clock(clock), .reset(reset), .x7_x0(x7_x0), .x_valid(x_valid), .x_ready(x_ready),
    .z7_z0(z7_z0), .z_valid(z_valid), .z_ready(z_ready)
`ifdef N8_SM2C2_NEGZERO_FLAG_EN
    , .nz(nz)
`endif
  );

`ifndef N8_SM2C2_NEGZERO_FLAG_EN
  assign nz = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: remaining busy cycles, then result = mag or -mag mod 256.
  logic       m_rdy, m_val, m_nz, p_nz;
  logic [7:0] m_z, p_z;
  int         m_remain;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_rdy = 1'b1; m_val = 1'b0; m_z = 8'h00; m_nz = 1'b0; m_remain = 0;
    end else if (m_rdy && x_valid) begin
      m_rdy = 1'b0;
      p_z   = x7_x0[7] ? 8'((256 - int'(x7_x0[6:0])) % 256) : {1'b0, x7_x0[6:0]};
      p_nz  = (x7_x0 == 8'h80);
      if (x7_x0[7]) m_remain = 8;
      else begin m_val = 1'b1; m_z = p_z; m_nz = p_nz; end
    end else if (m_remain > 0) begin
      m_remain--;
      if (m_remain == 0) begin m_val = 1'b1; m_z = p_z; m_nz = p_nz; end
    end else if (m_val && z_ready) begin
      m_val = 1'b0; m_rdy = 1'b1;
    end
  end

  always @(negedge clock) begin
    chk("cyc_x_ready", x_ready, m_rdy);
    chk("cyc_z_valid", z_valid, m_val);
    chk("cyc_z7_z0", z7_z0, m_z);
`ifdef N8_SM2C2_NEGZERO_FLAG_EN
    chk("cyc_nz", nz, m_nz);
`endif
  end

  // Drive one operand, measure latency, hold the result, then hand it off.
  task automatic op(input logic [7:0] x, input logic [7:0] ez, input int elat,
                    input logic enz, input int hold);
    int lat;
    logic [7:0] zs;
    @(negedge clock); #1;
    chk("pre_x_ready", x_ready, 1'b1);
    x7_x0 = x; x_valid = 1'b1; z_ready = 1'b0;
    @(posedge clock); #1;
    x_valid = 1'b0; x7_x0 = 8'h5A;
    lat = 1;
    while (!z_valid && lat < 20) begin
      chk("busy_x_ready", x_ready, 1'b0);
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", z7_z0, ez);
`ifdef N8_SM2C2_NEGZERO_FLAG_EN
    chk("nz_flag", nz, enz);
`else
    if (enz) chk("nz_absent", nz, 1'b0);
`endif
    zs = z7_z0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", z_valid, 1'b1);
      chk("hold_z", z7_z0, zs);
    end
    z_ready = 1'b1;
    @(posedge clock); #1;
    chk("post_valid", z_valid, 1'b0);
    chk("post_x_ready", x_ready, 1'b1);
  endtask

  initial begin
    #1;
    chk("rst_x_ready", x_ready, 1'b1);
    chk("rst_z_valid", z_valid, 1'b0);
    chk("rst_z", z7_z0, 8'h00);
    chk("rst_nz", nz, 1'b0);
    z_ready = 1'b1;  // no effect outside DONE
    repeat (2) @(negedge clock);
    reset = 1'b0;

    op(8'h05, 8'h05, 1, 1'b0, 0);
    op(8'h85, 8'hFB, 9, 1'b0, 0);
    op(8'hFF, 8'h81, 9, 1'b0, 0);
    op(8'h81, 8'hFF, 9, 1'b0, 0);
    op(8'h80, 8'h00, 9, 1'b1, 0);
    op(8'h7F, 8'h7F, 1, 1'b0, 0);
    op(8'h00, 8'h00, 1, 1'b0, 0);
    op(8'h85, 8'hFB, 9, 1'b0, 5);
    op(8'hC0, 8'hC0, 9, 1'b0, 1);

    // Reset mid-SHIFT discards the operation.
    @(negedge clock); #1;
    x7_x0 = 8'h85; x_valid = 1'b1; z_ready = 1'b0;
    @(posedge clock); #1;
    x_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_z_valid", z_valid, 1'b0);
    chk("arst_x_ready", x_ready, 1'b1);
    chk("arst_z", z7_z0, 8'h00);
    @(negedge clock); #1 reset = 1'b0;
    op(8'h03, 8'h03, 1, 1'b0, 0);
    op(8'h9A, 8'hE6, 9, 1'b0, 0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/n8_sm_to_c2_serial.md
N8_SM_TO_C2_SERIAL -- requirements
Module: n8_sm_to_c2_serial

Interface
REQ-001 Parameters SHALL be none; width is fixed at 8 bits.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 x7_x0  input  8  sign-magnitude operand: x7 is the sign, x6..x0 the magnitude.
REQ-005 x_valid  input  1  operand on x7_x0 is valid.
REQ-006 x_ready  output  1  block accepts an operand this cycle.
REQ-007 z7_z0  output  8  two's complement result, registered.
REQ-008 z_valid  output  1  z7_z0 holds a valid result.
REQ-009 z_ready  input  1  consumer accepts the result.
REQ-010 nz  output  1  negative-zero flag, valid with z_valid; present only under REQ-030.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 x_ready SHALL be 1 in IDLE and 0 in SHIFT and DONE.
REQ-013 An operand SHALL be accepted on any clock edge with x_valid=1 and x_ready=1; x7_x0 is sampled only at that edge.
REQ-014 On acceptance, the block SHALL latch sign=x7 and the working word {1'b0, x6..x0}.
REQ-015 On acceptance with sign=0, the block SHALL go to DONE with z7_z0 = {1'b0, x6..x0}, so z_valid=1 one cycle after acceptance.
REQ-016 On acceptance with sign=1, the block SHALL go to SHIFT, clear a 3-bit bit counter and clear the seen_one flag.
REQ-017 In SHIFT, each cycle SHALL process one working-word bit b, LSB first: result bit = b XOR seen_one; seen_one |= b; counter +1.
REQ-018 Within SHIFT, the bits SHALL be processed in the order bit0 through bit7, one per cycle, eight cycles in total.
REQ-019 After the cycle that processes bit7 (counter wrapping 7->0), the block SHALL enter DONE, so z_valid=1 nine cycles after acceptance.
REQ-020 The result for a negative operand SHALL equal the two's complement negation of the magnitude, modulo 2^8.
REQ-021 No overflow is possible, since every value in -127..+127 is representable; the block SHALL NOT have an overflow output.
REQ-022 Operand 8'h80 (negative zero) SHALL produce z7_z0=8'h00.
REQ-023 In DONE, z_valid SHALL be 1, and z7_z0 (and nz, when present) SHALL stay stable until the handshake completes.
REQ-024 When z_valid=1 and z_ready=1 at the same edge, the block SHALL return to IDLE; a new operand is accepted no earlier than the following edge.
REQ-025 When z_ready=1 in any state other than DONE, it SHALL have no effect.
REQ-026 While z7_z0 is not valid, it SHALL hold its previous value; its bits SHALL NOT be visible during SHIFT.

Reset
REQ-027 While reset=1, the block SHALL be in IDLE, with x_ready=1, z_valid=0, z7_z0=8'h00, nz=0, counter=0 and seen_one=0.
REQ-028 If reset is asserted in SHIFT or DONE, the operation in flight SHALL be discarded with no output handshake.
REQ-029 After reset deasserts, the first edge with x_valid=1 SHALL be accepted.

Configuration
REQ-030 The macro N8_SM2C2_NEGZERO_FLAG_EN SHALL control the negative-zero flag:
- Defined: port nz exists; nz=1 in DONE iff the accepted operand was 8'h80, otherwise nz=0.
- Undefined: port nz and its register are absent.
- All other behaviour and all timing SHALL be identical in both builds.

Verification
REQ-031 Scenario: reset, then x7_x0=8'h05 with x_valid=1 -> z_valid=1 one cycle later with z7_z0=8'h05 (nz=0).
REQ-032 Scenario: x7_x0=8'h85 -> x_ready=0 for 9 cycles; z_valid=1 on the 9th cycle after acceptance with z7_z0=8'hFB.
REQ-033 Scenario: x7_x0=8'hFF -> z7_z0=8'h81; x7_x0=8'h81 -> z7_z0=8'hFF; both with nine-cycle latency.
REQ-034 Scenario: x7_x0=8'h80 -> z7_z0=8'h00, and nz=1 when N8_SM2C2_NEGZERO_FLAG_EN is defined.
REQ-035 Scenario: result 8'hFB with z_ready held 0 for 5 cycles -> z7_z0 and z_valid stay stable; z_ready=1 -> IDLE on the next cycle with x_ready=1.
REQ-036 Scenario: reset pulsed on the 4th SHIFT cycle of 8'h85 -> immediately z_valid=0, x_ready=1, z7_z0=8'h00; the next operand 8'h03 gives 8'h03.
